btn_sw_conditioner: RTL and testbench



---
 rtl/btn_sw_conditioner_pkg.sv | 23 ++
 rtl/btn_sw_conditioner_if.sv | 29 ++
 rtl/btn_sw_conditioner_deb_bit.sv | 52 +++++
 rtl/btn_sw_conditioner.sv | 104 ++++++++++
 tb/tb_btn_sw_conditioner.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_sw_conditioner_pkg.sv
// Shared constants for the button/switch conditioner: default sizing, timing and
// the board button order used to build PORTI.
package btn_sw_conditioner_pkg;

   localparam int unsigned DEF_N_BTN        = 5;
   localparam int unsigned DEF_N_SW         = 16;
   localparam int unsigned DEF_TICK_DIV     = 100000;
   localparam int unsigned DEF_STABLE_TICKS = 10;
   localparam int unsigned DEF_REP_DELAY    = 500;
   localparam int unsigned DEF_REP_RATE     = 100;

   localparam int unsigned BTN_C = 0;
   localparam int unsigned BTN_D = 1;
   localparam int unsigned BTN_U = 2;
   localparam int unsigned BTN_R = 3;
   localparam int unsigned BTN_L = 4;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_sw_conditioner_if.sv
// Raw board inputs and conditioned outputs of btn_sw_conditioner; the slave
// modport is the conditioner side, the master modport its driver/consumer.
interface btn_sw_conditioner_if
   import btn_sw_conditioner_pkg::*;
#(
   parameter int unsigned N_BTN = DEF_N_BTN,
   parameter int unsigned N_SW  = DEF_N_SW
);

   logic [N_BTN-1:0] BTN_I;
   logic [N_SW-1:0]  SW_I;
   logic [N_BTN-1:0] BTN_O;
   logic [N_BTN-1:0] BTN_PRESS;
   logic [N_BTN-1:0] BTN_RELEASE;
   logic [N_SW-1:0]  SW_O;
   logic             SW_CHG;
   logic             TICK;

   modport master (
      output BTN_I, SW_I,
      input  BTN_O, BTN_PRESS, BTN_RELEASE, SW_O, SW_CHG, TICK
   );

   modport slave (
      input  BTN_I, SW_I,
      output BTN_O, BTN_PRESS, BTN_RELEASE, SW_O, SW_CHG, TICK
   );

endinterface

// File: rtl/btn_sw_conditioner_deb_bit.sv
// One input lane: 2-FF synchroniser, tick-driven debounce counter and
// registered rise/fall pulses aligned with the new stable level.
module deb_bit
   import btn_sw_conditioner_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW = cnt_width(STABLE_TICKS);

   logic [1:0]    sync;
   logic          stable;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync   <= '0;
         stable <= 1'b0;
         cnt    <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         rise <= 1'b0;
         fall <= 1'b0;
         if (tick) begin
            // Any tick agreeing with the stable value restarts qualification.
            if (sync[1] == stable) begin
               cnt <= '0;
            end else if (cnt == CW'(STABLE_TICKS - 1)) begin
               stable <= sync[1];
               cnt    <= '0;
               rise   <= sync[1];
               fall   <= ~sync[1];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign level = stable;

endmodule

// File: rtl/btn_sw_conditioner.sv
// Button/switch input conditioner: shared debounce prescaler, per-bit deb_bit lanes,
// SW_CHG reduction. Define BTN_AUTOREPEAT_EN to add held-button auto-repeat.
module btn_sw_conditioner
   import btn_sw_conditioner_pkg::*;
#(
   parameter int unsigned N_BTN        = DEF_N_BTN,
   parameter int unsigned N_SW         = DEF_N_SW,
   parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
   parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int unsigned REP_DELAY    = DEF_REP_DELAY,
   parameter int unsigned REP_RATE     = DEF_REP_RATE
) (
   input logic                  CLK,
   input logic                  RESET,
   btn_sw_conditioner_if.slave  bus
);

   localparam int unsigned PW = cnt_width(TICK_DIV);

   if (TICK_DIV < 2 || STABLE_TICKS < 1 || REP_RATE < 1 || REP_RATE > REP_DELAY
       || N_BTN <= BTN_L) begin : g_cfg_error
      $error("btn_sw_conditioner: unsupported parameter set");
   end

   logic [PW-1:0]    pre_cnt;
   logic             tick;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_rise;
   logic [N_SW-1:0]  sw_rise;
   logic [N_SW-1:0]  sw_fall;

   always_ff @(posedge CLK) begin
      if (RESET || pre_cnt == PW'(TICK_DIV - 1)) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick     = (pre_cnt == PW'(TICK_DIV - 1));
   assign bus.TICK = tick;

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      deb_bit #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
         .clk   (CLK),
         .rst   (RESET),
         .tick  (tick),
         .din   (bus.BTN_I[g]),
         .level (btn_level[g]),
         .rise  (btn_rise[g]),
         .fall  (bus.BTN_RELEASE[g])
      );
   end

   for (genvar g = 0; g < N_SW; g++) begin : g_sw
      deb_bit #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
         .clk   (CLK),
         .rst   (RESET),
         .tick  (tick),
         .din   (bus.SW_I[g]),
         .level (bus.SW_O[g]),
         .rise  (sw_rise[g]),
         .fall  (sw_fall[g])
      );
   end

   assign bus.BTN_O  = btn_level;
   assign bus.SW_CHG = |(sw_rise | sw_fall);

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned RW = cnt_width(REP_DELAY);

   logic [RW-1:0]    rep_cnt [N_BTN];
   logic [N_BTN-1:0] rep_pulse;

   // Reloading REP_DELAY-REP_RATE after each repeat makes later repeats land
   // every REP_RATE ticks without a second counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rep_pulse <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) rep_cnt[i] <= '0;
      end else begin
         rep_pulse <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            if (!btn_level[i]) begin
               rep_cnt[i] <= '0;
            end else if (tick) begin
               if (rep_cnt[i] == RW'(REP_DELAY - 1)) begin
                  rep_pulse[i] <= 1'b1;
                  rep_cnt[i]   <= RW'(REP_DELAY - REP_RATE);
               end else begin
                  rep_cnt[i] <= rep_cnt[i] + 1'b1;
               end
            end
         end
      end
   end

   assign bus.BTN_PRESS = btn_rise | rep_pulse;
`else
   assign bus.BTN_PRESS = btn_rise;
`endif

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Randomised self-checking bench for btn_sw_conditioner against a tick-sampling
// reference model; build with BTN_AUTOREPEAT_EN to cover auto-repeat.
module tb_btn_sw_conditioner;

   localparam int TD = 4;
   localparam int ST = 3;
   localparam int RD = 5;
   localparam int RR = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   btn_sw_conditioner_if #(.N_BTN(5), .N_SW(16)) bus ();

   btn_sw_conditioner #(
      .N_BTN(5), .N_SW(16), .TICK_DIV(TD), .STABLE_TICKS(ST),
      .REP_DELAY(RD), .REP_RATE(RR)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   // Reference: inputs seen two clocks late, sampled only on every TD-th clock
   // after reset; a level is accepted after ST consecutive differing samples.
   logic [20:0] h1 = '0, h2 = '0, m_st = '0;
   int          run [21];
   int          held [5];
   int          edges = 0;
   logic [4:0]  e_press = '0, e_rel = '0;
   logic        e_chg = 1'b0;

   always @(posedge clk) begin
      logic [20:0] samp;
      e_press = '0;
      e_rel   = '0;
      e_chg   = 1'b0;
      if (rst) begin
         h1 = '0; h2 = '0; m_st = '0; edges = 0;
         foreach (run[i]) run[i] = 0;
         foreach (held[i]) held[i] = 0;
      end else begin
         samp = h2;
         h2   = h1;
         h1   = {bus.SW_I, bus.BTN_I};
         if (edges % TD == TD - 1) begin
`ifdef BTN_AUTOREPEAT_EN
            for (int i = 0; i < 5; i++) begin
               if (m_st[i]) begin
                  held[i]++;
                  if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RR == 0))
                     e_press[i] = 1'b1;
               end
            end
`endif
            for (int i = 0; i < 21; i++) begin
               if (samp[i] === m_st[i]) run[i] = 0;
               else begin
                  run[i]++;
                  if (run[i] == ST) begin
                     m_st[i] = samp[i];
                     run[i]  = 0;
                     if (i < 5) begin
                        held[i] = 0;
                        if (samp[i]) e_press[i] = 1'b1;
                        else         e_rel[i]   = 1'b1;
                     end else e_chg = 1'b1;
                  end
               end
            end
         end
         edges++;
      end
   end

   function automatic logic [32:0] exp_v();
      logic t;
      t = (!rst || edges != 0) && (edges % TD == TD - 1);
      return {m_st[4:0], e_press, e_rel, m_st[20:5], e_chg, t};
   endfunction

   function automatic logic [32:0] obs_v();
      return {bus.BTN_O, bus.BTN_PRESS, bus.BTN_RELEASE, bus.SW_O, bus.SW_CHG, bus.TICK};
   endfunction

   task automatic test_reset();
      int np = 0;
      int first_tick = -1;
      rst = 1'b1;
      bus.BTN_I = 5'h1F;
      bus.SW_I  = '0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== 33'd0) begin
            errors++; $display("FAIL reset_zero: got %h want 0", obs_v());
         end
      end
      rst = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL reset_model c=%0d: got %h want %h", c, obs_v(), exp_v());
         end
         if (bus.TICK && first_tick < 0) first_tick = c;
         if (bus.BTN_PRESS == 5'h1F) np++;
      end
      checks++;
      if (first_tick !== TD - 1) begin
         errors++; $display("FAIL reset_first_tick: got %0d want %0d", first_tick, TD - 1);
      end
      checks++;
      if (np !== 1) begin
         errors++; $display("FAIL reset_press_1f: got %0d pulses want 1", np);
      end
      checks++;
      if (bus.BTN_O !== 5'h1F) begin
         errors++; $display("FAIL reset_btn_o: got %h want 1f", bus.BTN_O);
      end
   endtask

   task automatic settle(input logic [4:0] btn, input logic [15:0] sw);
      bus.BTN_I = btn;
      bus.SW_I  = sw;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL settle_model: got %h want %h", obs_v(), exp_v());
         end
      end
   endtask

   task automatic test_clean_press();
      int lat = -1;
      int nr  = 0;
      repeat ($urandom_range(0, TD - 1)) @(negedge clk);
      bus.BTN_I[0] = 1'b1;
      for (int c = 1; c <= 2 + ST * TD + 2; c++) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL press_model c=%0d: got %h want %h", c, obs_v(), exp_v());
         end
         if (bus.BTN_PRESS[0] && lat < 0) lat = c;
      end
      checks++;
      if (lat < 0 || lat > 2 + ST * TD) begin
         errors++; $display("FAIL press_latency: got %0d want 1..%0d", lat, 2 + ST * TD);
      end
      bus.BTN_I[0] = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL release_model c=%0d: got %h want %h", c, obs_v(), exp_v());
         end
         if (bus.BTN_RELEASE[0]) nr++;
      end
      checks++;
      if (nr !== 1 || bus.BTN_O[0] !== 1'b0) begin
         errors++; $display("FAIL release_once: got %0d pulses level %b want 1 pulse level 0", nr, bus.BTN_O[0]);
      end
   endtask

   task automatic test_bounce();
      int np = 0;
      int early = 0;
      repeat ($urandom_range(0, TD - 1)) @(negedge clk);
      bus.BTN_I[2] = 1'b1;
      for (int c = 0; c < 8 * TD; c++) begin
         if (c == 2 * TD) bus.BTN_I[2] = 1'b0;
         if (c == 3 * TD) bus.BTN_I[2] = 1'b1;
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL bounce_model c=%0d: got %h want %h", c, obs_v(), exp_v());
         end
         if (bus.BTN_PRESS[2]) begin
            np++;
            if (c < 5 * TD) early++;
         end
      end
      checks++;
      if (np !== 1 || early !== 0 || bus.BTN_O[2] !== 1'b1) begin
         errors++; $display("FAIL bounce_press: got %0d pulses (%0d early) level %b want 1 (0) 1", np, early, bus.BTN_O[2]);
      end
   endtask

   task automatic test_switches();
      int nchg = 0;
      int guard = 0;
      bus.SW_I = 16'hA5A5;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL sw_model c=%0d: got %h want %h", c, obs_v(), exp_v());
         end
         if (bus.SW_CHG) nchg++;
      end
      checks++;
      if (nchg !== 1 || bus.SW_O !== 16'hA5A5) begin
         errors++; $display("FAIL sw_change: got %0d pulses SW_O %h want 1 a5a5", nchg, bus.SW_O);
      end
      while (!bus.TICK && guard < 2 * TD) begin
         @(negedge clk);
         guard++;
      end
      nchg = 0;
      bus.SW_I[15] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.SW_I[15] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL glitch_model c=%0d: got %h want %h", c, obs_v(), exp_v());
         end
         if (bus.SW_CHG) nchg++;
      end
      checks++;
      if (nchg !== 0 || bus.SW_O !== 16'hA5A5) begin
         errors++; $display("FAIL sw_glitch: got %0d pulses SW_O %h want 0 a5a5", nchg, bus.SW_O);
      end
   endtask

   task automatic test_simultaneous();
      int n12 = 0;
      int nother = 0;
      int guard = 0;
      int pc = -1;
      bus.BTN_I = 5'h12;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL simul_model c=%0d: got %h want %h", c, obs_v(), exp_v());
         end
         if (bus.BTN_PRESS == 5'h12) n12++;
         else if (bus.BTN_PRESS != 5'h00) nother++;
      end
      checks++;
      if (n12 !== 1 || nother !== 0) begin
         errors++; $display("FAIL simul_press: got %0d joint %0d other want 1 0", n12, nother);
      end
      settle(5'h00, 16'hA5A5);
      bus.BTN_I[0] = 1'b1;
      while (run[0] != 2 && guard < 10 * TD) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (run[0] != 2) begin
         errors++; $display("FAIL midqual_timeout: got %0d qualifying ticks want 2", run[0]);
      end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== 33'd0) begin
            errors++; $display("FAIL midqual_reset: got %h want 0", obs_v());
         end
      end
      rst = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL midqual_model c=%0d: got %h want %h", c, obs_v(), exp_v());
         end
         if (bus.BTN_PRESS[0] && pc < 0) pc = c;
      end
      checks++;
      if (pc !== ST * TD) begin
         errors++; $display("FAIL midqual_restart: got press at %0d want %0d", pc, ST * TD);
      end
   endtask

   task automatic test_autorepeat();
      int t_acc = -1;
      int offs[$];
      bus.BTN_I[3] = 1'b1;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL repeat_model c=%0d: got %h want %h", c, obs_v(), exp_v());
         end
         if (bus.BTN_PRESS[3]) begin
            if (t_acc < 0) t_acc = c;
            offs.push_back(c - t_acc);
         end
         if (t_acc >= 0 && c == t_acc + 13 * TD + 2) break;
      end
      bus.BTN_I[3] = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      checks++;
      if (offs.size() !== 6) begin
         errors++; $display("FAIL repeat_count: got %0d want 6", offs.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            int want;
            want = (k == 0) ? 0 : TD * (RD + RR * (k - 1));
            checks++;
            if (offs[k] !== want) begin
               errors++; $display("FAIL repeat_time k=%0d: got %0d want %0d", k, offs[k], want);
            end
         end
      end
`else
      checks++;
      if (offs.size() !== 1) begin
         errors++; $display("FAIL repeat_none: got %0d pulses want 1", offs.size());
      end
`endif
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 9) == 0) bus.BTN_I[$urandom_range(0, 4)] ^= 1'b1;
         if ($urandom_range(0, 9) == 0) bus.SW_I = bus.SW_I ^ 16'($urandom_range(1, 16'hFFFF));
         @(negedge clk);
         checks++;
         if (obs_v() !== exp_v()) begin
            errors++; $display("FAIL random_model c=%0d: got %h want %h", c, obs_v(), exp_v());
         end
      end
   endtask

   initial begin
      bus.BTN_I = '0;
      bus.SW_I  = '0;
      test_reset();
      settle(5'h00, 16'h0000);
      test_clean_press();
      test_bounce();
      settle(5'h00, 16'h0000);
      test_switches();
      test_simultaneous();
      settle(5'h00, 16'hA5A5);
      test_autorepeat();
      settle(5'h00, 16'hA5A5);
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
